// File: rtl/ex_muldiv_if.sv
// Handshake and operand/result bundle between the EX stage and the iterative RV32M unit.
interface ex_muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] ALU_in1;
  logic [XLEN-1:0] ALU_in2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct3, ALU_in1, ALU_in2,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, ALU_in1, ALU_in2,
    output busy, done, result
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);

  localparam int unsigned W  = XLEN;
  localparam int unsigned AW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [2:0]    op;
  logic [W-1:0]  bmag;
  logic [AW-1:0] acc;
  logic [W:0]    rem;
  logic          neg;
  logic          special;
  logic [W-1:0]  spec_q;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;

  // Acceptance-time decode: signedness, magnitudes, result sign, special cases
  logic          s1, s2, a_neg, b_neg, res_neg, div_zero, div_ovf;
  logic [W-1:0]  a_mag, b_mag, spec_val;
  // Per-iteration datapath and final fix-up
  logic [W:0]    msum;
  logic [AW-1:0] mul_next;
  logic [W+1:0]  dshift;
  logic          ge;
  logic [W:0]    ddiff, rem_next;
  logic [W-1:0]  q_next;
  logic [AW-1:0] prod;
  logic [W-1:0]  q_fix, r_fix, fin_val;

  always_comb begin
    s1       = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
               (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    s2       = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
               (bus.funct3 == 3'b110);
    a_neg    = s1 & bus.ALU_in1[W-1];
    b_neg    = s2 & bus.ALU_in2[W-1];
    a_mag    = a_neg ? -bus.ALU_in1 : bus.ALU_in1;
    b_mag    = b_neg ? -bus.ALU_in2 : bus.ALU_in2;
    // Remainder takes the dividend's sign; products and quotients the XOR
    res_neg  = (bus.funct3 == 3'b110) ? a_neg : (a_neg ^ b_neg);
    div_zero = bus.funct3[2] && (bus.ALU_in2 == '0);
    div_ovf  = ((bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) &&
               (bus.ALU_in1 == MIN_NEG) && (bus.ALU_in2 == '1);
    spec_val = '0;
    if (div_zero) begin
      spec_val = bus.funct3[1] ? bus.ALU_in1 : '1;
    end else if (div_ovf) begin
      spec_val = bus.funct3[1] ? '0 : MIN_NEG;
    end
  end

  always_comb begin
    // Shift-add: add multiplicand into upper half when multiplier LSB is set, then shift right
    msum     = {1'b0, acc[AW-1:W]} + (acc[0] ? {1'b0, bmag} : '0);
    mul_next = {msum, acc[W-1:1]};
    // Restoring divide: shift in next dividend bit, subtract divisor if it fits
    dshift   = {rem, acc[W-1]};
    ge       = dshift >= (W+2)'(bmag);
    ddiff    = dshift[W:0] - (W+1)'(bmag);
    rem_next = ge ? ddiff : dshift[W:0];
    q_next   = {acc[W-2:0], ge};
    prod     = neg ? -acc : acc;
    q_fix    = neg ? -acc[W-1:0] : acc[W-1:0];
    r_fix    = neg ? -rem[W-1:0] : rem[W-1:0];
    if (op[2]) begin
      fin_val = op[1] ? r_fix : q_fix;
    end else begin
      fin_val = (op == 3'b000) ? prod[W-1:0] : prod[AW-1:W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      op      <= '0;
      bmag    <= '0;
      acc     <= '0;
      rem     <= '0;
      neg     <= 1'b0;
      special <= 1'b0;
      spec_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            op    <= bus.funct3;
            bmag  <= b_mag;
            neg   <= res_neg;
            acc   <= {{W{1'b0}}, a_mag};
            rem   <= '0;
            count <= '0;
            if (div_zero || div_ovf) begin
              special <= 1'b1;
              spec_q  <= spec_val;
              state   <= DONE;
            end else begin
              special <= 1'b0;
              busy    <= 1'b1;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (op[2]) begin
              rem          <= rem_next;
              acc[W-1:0]   <= q_next;
            end else begin
              acc <= mul_next;
            end
            count <= count + 1'b1;
            if (count == LAST_CNT) begin
              busy  <= 1'b0;
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          if (!bus.flush) begin
            done   <= 1'b1;
            result <= special ? spec_q : fin_val;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed vector bench for ex_muldiv_unit: results, latencies, flush and async reset.
module tb_ex_muldiv_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ex_muldiv_if #(.XLEN(32)) bus ();

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one op, hold start until done, scramble inputs after acceptance
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busyc);
    int e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct3 = f;
    bus.ALU_in1 = a;
    bus.ALU_in2 = b;
    @(posedge clk); #1;
    bus.ALU_in1 = ~a;
    bus.ALU_in2 = a ^ 32'h5A5A_1234;
    bus.funct3 = ~f;
    e = 0;
    busyc = 0;
    while (!bus.done && e < 100) begin
      if (bus.busy) busyc++;
      @(posedge clk); #1;
      e++;
    end
    bus.start = 1'b0;
    res = bus.result;
    lat = e;
    @(posedge clk); #1;
    check("done_pulse_width", 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] prev;
    int lat, busyc, pulses;

    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.funct3 = 3'b000;
    bus.ALU_in1 = '0;
    bus.ALU_in2 = '0;

    vecs[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'b101, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 33};
    vecs[7]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[8]  = '{3'b110, 32'd5,         32'd0,         32'd5,         1};
    vecs[9]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[10] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[11] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[12] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};
    vecs[13] = '{3'b111, 32'd100,       32'd7,         32'd2,         33};
    vecs[14] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         33};
    vecs[15] = '{3'b000, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 33};
    vecs[16] = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};

    #12;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);
    #11 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, busyc);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy_cycles", i), 32'(busyc), (vecs[i].lat == 33) ? 32'd32 : 32'd0);
    end
    prev = 32'hFFFF_FFFF;

    // Flush at count 10: back to IDLE, no done, result kept
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct3 = 3'b000;
    bus.ALU_in1 = 32'h0000_1234;
    bus.ALU_in2 = 32'd5;
    @(posedge clk); #1;
    repeat (10) begin @(posedge clk); #1; end
    check("flush_busy_before", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy_after", 32'(bus.busy), 32'd0);
    check("flush_done_after", 32'(bus.done), 32'd0);
    check("flush_result_kept", bus.result, prev);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    check("flush_no_late_done", 32'(pulses), 32'd0);
    check("flush_result_still", bus.result, prev);

    run_op(3'b000, 32'd3, 32'd4, res, lat, busyc);
    check("post_flush_mul", res, 32'd12);
    check("post_flush_latency", 32'(lat), 32'd33);

    // Async reset mid-CALC, away from any clock edge
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct3 = 3'b011;
    bus.ALU_in1 = 32'd9;
    bus.ALU_in2 = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_busy", 32'(bus.busy), 32'd0);
    check("async_reset_done", 32'(bus.done), 32'd0);
    check("async_reset_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // start together with flush in IDLE: not accepted
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.funct3 = 3'b101;
    bus.ALU_in1 = 32'd5;
    bus.ALU_in2 = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("start_flush_busy", 32'(bus.busy), 32'd0);
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    check("start_flush_no_done", 32'(pulses), 32'd0);
    check("start_flush_result", bus.result, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage. It consumes the forwarded operands `ALU_in1` and `ALU_in2` (the output of the EX operand-select muxes) whenever the decoded instruction is an M-extension op. It computes the result over multiple cycles and returns a 32-bit result with a one-cycle `done` pulse. While it works, the hazard unit holds IF/ID/EX (stall until `done`) and bubbles EX/MEM.

## Interface
- `XLEN`, default 32: operand/result width. Only 32 is supported.
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst`: input, 1 bit. Reset is asynchronous and active-high.
- `start`: input, 1 bit. Request to begin an op; sampled only in IDLE.
- `flush`: input, 1 bit. Aborts the current op (branch mispredict or trap).
- `funct3`: input, 3 bits. RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `ALU_in1`: input, 32 bits. rs1 operand, already forwarded.
- `ALU_in2`: input, 32 bits. rs2 operand, already forwarded or imm-selected.
- `busy`: output, 1 bit. High while in CALC.
- `done`: output, 1 bit. One-cycle pulse; `result` is valid this cycle.
- `result`: output, 32 bits. Last completed result; held until the next `done`.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE:**
  - `start` && !`flush` latches `funct3` and both operands.
  - Special case detected → DONE.
  - Otherwise → CALC with count = 0.
- **Operand preparation:**
  - Signed operands (MULH rs1/rs2, MULHSU rs1, DIV/REM both) are converted to magnitudes.
  - The result sign is recorded:
    - MUL*: the XOR of the operand signs.
    - Quotient: the XOR of the operand signs.
    - Remainder: the sign of the dividend.
- **Multiply:**
  - Shift-add, 1 multiplier bit per cycle, 64-bit accumulator.
  - After 32 iterations, conditionally negate the 64-bit product (two's complement).
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- **Divide:**
  - Restoring, 1 quotient bit per cycle.
  - 33-bit partial remainder; subtract the divisor when non-negative.
  - After 32 iterations, apply the sign fix-up.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- **CALC:** count increments each cycle. At count == 31 the final iteration is performed and the state moves to DONE.
- **DONE:**
  - `result` is registered and `done` = 1 for exactly one cycle.
  - Next state is IDLE.
  - `start` is not accepted in DONE.
- **Special cases** (IDLE→DONE directly, no iteration):
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend.
  - Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- **flush:**
  - In any state, the next state is IDLE.
  - `done` is not asserted.
  - `result` is unchanged.
  - flush and start in the same IDLE cycle: flush wins, op not started.
- `start` while in CALC or DONE is ignored. The hazard unit must hold `start` asserted until `done`.
- Operands are latched at acceptance. Later changes on `ALU_in1`/`ALU_in2` (forwarding updates) have no effect on an op in flight.

## Timing
- **Reset values:**
  - state = IDLE, count = 0.
  - `busy` = 0, `done` = 0, `result` = 0x00000000.
  - All internal registers are cleared.
- `busy` and `done` are registered, not combinational from inputs.
- **Normal latency:** `start` is sampled at edge E0. `busy` = 1 for the 32 cycles after E0. `done` = 1 in the cycle after edge E0+33, i.e. 34 cycles of stall including the start cycle.
- **Special-case latency:** `done` = 1 in the cycle after edge E0+1.
- Back-to-back ops: the earliest next `start` is sampled at the edge that leaves DONE, so DONE→IDLE takes one cycle before acceptance.
- `rst` asserted mid-CALC immediately forces the reset values, independent of the clock.

## Test plan
- **MUL and MULH:**
  - MUL 7 × 0xFFFFFFFD (−3) → `result` 0xFFFFFFEB, `done` exactly 33 edges after start, `busy` high 32 cycles.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Signed divide:**
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM −7 % 2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- **Divide by zero:**
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 % 0 → 5.
  - Each `done` at 1 edge after start, `busy` never high.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM → 0. Both finish with 1-cycle latency.
- **Flush mid-op:** assert `flush` at count 10 → IDLE next edge, no `done`, `result` retains its previous value. A following MUL 3 × 4 → 12 with normal latency.
- **Async reset:** `rst` pulse mid-CALC (no clock edge) → `busy`/`done` drop to 0 and `result` = 0 immediately. Start in the same IDLE cycle as `flush` → ignored.
